// File: rtl/smps_pkg.sv
// Shared definitions for the SMPS power-stage sequencer: state codes,
// fault-cause bit positions, duty width and a duty clamp helper.
package smps_pkg;

    // Duty word width used by soft_start, compensator and soft_shutdown
    localparam int DUTY_W = 10;

    // Sequencer state codes (visible on o_state)
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SOFT_START = 3'd1,
        REGULATE   = 3'd2,
        SHUTDOWN   = 3'd3,
        FAULT      = 3'd4
    } seq_state_t;

    // Bit positions inside the latched fault word {TMO, OTP, UVLO, OVP}
    localparam int OVP  = 0;
    localparam int UVLO = 1;
    localparam int OTP  = 2;
    localparam int TMO  = 3;

    // Number of ADC-driven fault filters (OVP, UVLO, OTP)
    localparam int NUM_FILT = 3;

    // Limit a duty word to an upper bound
    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] duty,
        input logic [DUTY_W-1:0] dmax
    );
        return (duty > dmax) ? dmax : duty;
    endfunction

endpackage

// File: rtl/smps_seq_ctrl_filter.sv
// Consecutive-sample fault filter. Each valid ADC sample either bumps a
// saturating violation counter or clears it. The trip/violation flags look
// at the count this cycle's sample produces, so the sequencer can react on
// the same clock edge that registers the offending sample.
module seq_fault_filter #(
    parameter logic [11:0] TH    = 12'd0,
    parameter bit          ABOVE = 1'b1,   // 1: code > TH violates, 0: code < TH violates
    parameter int          CNT   = 4       // consecutive violations to trip, 1..15
) (
    input  logic        i_clk,
    input  logic        reset_n,
    input  logic        i_valid,
    input  logic [11:0] i_code,
    output logic        o_trip,
    output logic        o_viol
);

    localparam logic [3:0] CNT_MAX = 4'(CNT);

    logic       bad;
    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    // Classify the sample and compute the post-sample count
    always_comb begin
        bad      = ABOVE ? (i_code > TH) : (i_code < TH);
        cnt_next = cnt_reg;
        if (i_valid) begin
            if (!bad) begin
                cnt_next = 4'd0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + 4'd1;
            end
        end
    end

    // Violation counter register
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign o_trip = (cnt_next == CNT_MAX);
    assign o_viol = (cnt_next != 4'd0);

endmodule

// File: rtl/smps_seq_ctrl.sv
// Power-stage sequencer: owns DPWM enable and duty-source selection.
// Walks the converter IDLE -> SOFT_START -> REGULATE -> SHUTDOWN -> IDLE and
// latches a FAULT on OVP / UVLO / OTP filter trips or a soft-start timeout.
// Every output is registered and derived from the next state, so an input
// event shows up on the outputs one clock later.
module smps_seq_ctrl
    import smps_pkg::*;
#(
    parameter logic [DUTY_W-1:0] DMAX       = 10'd900,
    parameter logic [11:0]       OVP_TH     = 12'd3500,
    parameter logic [11:0]       UVLO_TH    = 12'd1200,
    parameter logic [11:0]       OTP_TH     = 12'd3000,
    parameter int                FLT_CNT    = 4,
    parameter logic [23:0]       SS_TIMEOUT = 24'd2_000_000
) (
    input  logic              i_clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_clear,
    input  logic [DUTY_W-1:0] i_ss_duty,
    input  logic              i_ss_done,
    input  logic [DUTY_W-1:0] i_comp_duty,
    input  logic [DUTY_W-1:0] i_sd_duty,
    input  logic              i_sd_done,
    input  logic              i_adc_valid,
    input  logic [11:0]       i_adc_vo,
    input  logic [11:0]       i_adc_vin,
    input  logic [11:0]       i_adc_temp,
    output logic              o_ss_en,
    output logic              o_comp_en,
    output logic              o_sd_en,
    output logic              o_sd_load,
    output logic              o_dpwm_en,
    output logic [DUTY_W:0]   o_ton,
    output logic [2:0]        o_state,
    output logic [3:0]        o_fault
);

    // ------------------------------------------------------------------
    // Fault filters, one per ADC channel
    // ------------------------------------------------------------------
    logic [11:0]         adc_code [NUM_FILT];
    logic [NUM_FILT-1:0] filt_trip;
    logic [NUM_FILT-1:0] filt_viol;

    assign adc_code[OVP]  = i_adc_vo;
    assign adc_code[UVLO] = i_adc_vin;
    assign adc_code[OTP]  = i_adc_temp;

    generate
        for (genvar gi = 0; gi < NUM_FILT; gi++) begin : g_filt
            // Under-voltage is the only channel that trips below its threshold
            seq_fault_filter #(
                .TH   ((gi == OVP) ? OVP_TH : ((gi == UVLO) ? UVLO_TH : OTP_TH)),
                .ABOVE(gi != UVLO),
                .CNT  (FLT_CNT)
            ) u_filt (
                .i_clk  (i_clk),
                .reset_n(reset_n),
                .i_valid(i_adc_valid),
                .i_code (adc_code[gi]),
                .o_trip (filt_trip[gi]),
                .o_viol (filt_viol[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Sequencer state and registered outputs
    // ------------------------------------------------------------------
    seq_state_t        state_reg,   state_next;
    logic [3:0]        fault_reg,   fault_next;
    logic [23:0]       ss_cnt_reg,  ss_cnt_next;
    logic              ss_en_reg,   ss_en_next;
    logic              comp_en_reg, comp_en_next;
    logic              sd_en_reg,   sd_en_next;
    logic              sd_load_reg, sd_load_next;
    logic              dpwm_en_reg, dpwm_en_next;
    logic [DUTY_W:0]   ton_reg,     ton_next;

    logic              tmo;
    logic [3:0]        trips;
    logic              any_trip;
    logic              any_viol;
    logic              running;

    // Next state, fault latch, timeout counter and next output values
    always_comb begin
        tmo             = (state_reg == SOFT_START) && (ss_cnt_reg == SS_TIMEOUT - 24'd1);
        trips           = 4'd0;
        trips[OVP]      = filt_trip[OVP];
        trips[UVLO]     = filt_trip[UVLO];
        trips[OTP]      = filt_trip[OTP];
        trips[TMO]      = tmo;
        any_trip        = |trips;
        any_viol        = |filt_viol;
        running         = (state_reg == SOFT_START) || (state_reg == REGULATE) ||
                          (state_reg == SHUTDOWN);

        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_start && !any_viol && (fault_reg == 4'd0)) begin
                    state_next = SOFT_START;
                end
            end
            SOFT_START: begin
                if (any_trip) begin
                    state_next = FAULT;
                end else if (i_stop) begin
                    state_next = SHUTDOWN;
                end else if (i_ss_done) begin
                    state_next = REGULATE;
                end
            end
            REGULATE: begin
                if (any_trip) begin
                    state_next = FAULT;
                end else if (i_stop || !i_start) begin
                    state_next = SHUTDOWN;
                end
            end
            SHUTDOWN: begin
                if (any_trip) begin
                    state_next = FAULT;
                end else if (i_sd_done) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                if (i_clear && !i_start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Fault causes accumulate while faulted and are wiped only by a clear
        fault_next = fault_reg;
        if (state_reg == FAULT) begin
            fault_next = (state_next == IDLE) ? 4'd0 : (fault_reg | trips);
        end else if (running && (state_next == FAULT)) begin
            fault_next = fault_reg | trips;
        end

        // Held at zero outside SOFT_START so each entry starts a fresh window
        ss_cnt_next = (state_reg == SOFT_START) ? (ss_cnt_reg + 24'd1) : 24'd0;

        ss_en_next   = 1'b0;
        comp_en_next = 1'b0;
        sd_en_next   = 1'b0;
        sd_load_next = 1'b0;
        dpwm_en_next = 1'b0;
        ton_next     = '0;
        case (state_next)
            SOFT_START: begin
                ss_en_next   = 1'b1;
                dpwm_en_next = 1'b1;
                ton_next     = {1'b0, i_ss_duty};
            end
            REGULATE: begin
                comp_en_next = 1'b1;
                dpwm_en_next = 1'b1;
                ton_next     = {1'b0, clamp_duty(i_comp_duty, DMAX)};
            end
            SHUTDOWN: begin
                sd_en_next   = 1'b1;
                dpwm_en_next = 1'b1;
                if (state_reg != SHUTDOWN) begin
                    // soft_shutdown ramps down from the on-time in force right now
                    sd_load_next = 1'b1;
                    ton_next     = ton_reg;
                end else begin
                    ton_next     = {1'b0, i_sd_duty};
                end
            end
            default: ;
        endcase
    end

    // State, fault latch, timeout counter and output registers
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            fault_reg   <= 4'd0;
            ss_cnt_reg  <= 24'd0;
            ss_en_reg   <= 1'b0;
            comp_en_reg <= 1'b0;
            sd_en_reg   <= 1'b0;
            sd_load_reg <= 1'b0;
            dpwm_en_reg <= 1'b0;
            ton_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            fault_reg   <= fault_next;
            ss_cnt_reg  <= ss_cnt_next;
            ss_en_reg   <= ss_en_next;
            comp_en_reg <= comp_en_next;
            sd_en_reg   <= sd_en_next;
            sd_load_reg <= sd_load_next;
            dpwm_en_reg <= dpwm_en_next;
            ton_reg     <= ton_next;
        end
    end

    assign o_ss_en   = ss_en_reg;
    assign o_comp_en = comp_en_reg;
    assign o_sd_en   = sd_en_reg;
    assign o_sd_load = sd_load_reg;
    assign o_dpwm_en = dpwm_en_reg;
    assign o_ton     = ton_reg;
    assign o_state   = state_reg;
    assign o_fault   = fault_reg;

endmodule

// File: doc/smps_seq_ctrl.md
# smps_seq_ctrl

Power-stage sequencer for the SMPS controller: one FSM that owns the DPWM enable and duty-source selection. It steps the converter through soft-start, closed-loop regulation and soft-shutdown, and forces a latched fault state on over-voltage, input under-voltage, over-temperature or soft-start timeout. It sits between the soft_start, compensator, soft_shutdown and ADC blocks and the dpwm generator. It replaces ad-hoc top-level duty muxing.

## Interface
- DMAX, 10'd900, upper clamp applied to compensator duty
- OVP_TH, 12'd3500, output-voltage trip level (adc_vo[11:0] above this is a violation)
- UVLO_TH, 12'd1200, input-voltage lockout level (adc_vin[11:0] below this is a violation)
- OTP_TH, 12'd3000, temperature trip level (above is a violation)
- FLT_CNT, 4, consecutive violating samples needed to trip; range 1..15
- SS_TIMEOUT, 24'd2_000_000, max i_clk cycles allowed in SOFT_START
- i_clk  in  1  200 MHz core clock
- reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  level request to run
- i_stop  in  1  level request for soft shutdown
- i_clear  in  1  fault clear; honoured only while i_start=0
- i_ss_duty  in  10  soft_start duty
- i_ss_done  in  1  soft_start finished
- i_comp_duty  in  10  compensator duty
- i_sd_duty  in  10  soft_shutdown duty
- i_sd_done  in  1  soft_shutdown reached zero
- i_adc_valid  in  1  1-cycle strobe; new ADC set present
- i_adc_vo, i_adc_vin, i_adc_temp  in  12 each  ADC codes
- o_ss_en, o_comp_en, o_sd_en  out  1 each  sub-block enables
- o_sd_load  out  1  1-cycle pulse; soft_shutdown loads o_ton
- o_dpwm_en  out  1  DPWM enable
- o_ton  out  11  DPWM on-time, {1'b0, duty}
- o_state  out  3  current state code
- o_fault  out  4  latched causes {TMO, OTP, UVLO, OVP}

## Operation
- States: IDLE=0, SOFT_START=1, REGULATE=2, SHUTDOWN=3, FAULT=4. Priority on every cycle: fault trip > i_stop > normal progress.
- IDLE: all enables 0, o_ton=0.
  - Go to SOFT_START when i_start=1, no filter is currently in violation and o_fault=0.
- SOFT_START: o_ss_en=1, o_dpwm_en=1, o_ton=i_ss_duty.
  - i_ss_done → REGULATE.
  - i_stop → SHUTDOWN.
  - Timeout counter reaching SS_TIMEOUT → FAULT with TMO set.
- REGULATE: o_comp_en=1, o_dpwm_en=1, o_ton=min(i_comp_duty, DMAX).
  - i_stop or i_start falling to 0 → SHUTDOWN.
- SHUTDOWN: o_sd_en=1, o_dpwm_en=1, o_ton=i_sd_duty.
  - i_sd_done → IDLE.
  - Fault trips are still honoured.
- Entry to SHUTDOWN: o_sd_load pulses for exactly one cycle, with o_ton holding the pre-transition value that same cycle.
- FAULT: all enables 0, o_ton=0.
  - Exit to IDLE only on i_clear=1 & i_start=0, which also clears o_fault.
  - New trips while in FAULT OR into o_fault.
- Fault filters (OVP, UVLO, OTP), evaluated only on i_adc_valid:
  - Violating sample: counter +1, saturating at FLT_CNT.
  - Good sample: counter → 0.
  - Trip when count==FLT_CNT. A trip forces FAULT only from SOFT_START, REGULATE or SHUTDOWN.
  - In IDLE, a tripped or partial count only blocks start.
- Simultaneous trips set all corresponding o_fault bits in the same cycle.
- Simultaneous i_ss_done and i_stop → SHUTDOWN.

## Timing
- All outputs are registered. Reset value of every output is 0, and o_state=IDLE.
- Latency from an input event to the state change and the new outputs: 1 cycle.
- Fault trip to o_dpwm_en=0: 1 cycle after the FLT_CNT-th violating i_adc_valid.
- The SS_TIMEOUT counter clears on SOFT_START entry and counts every cycle in that state. Trip occurs on the cycle its value equals SS_TIMEOUT-1.
- Asserting reset_n low mid-operation immediately zeroes all outputs, counters and o_fault, asynchronously.

## Structure
- The shared package smps_pkg holds:
  - the seq_state_t enum (state codes above);
  - fault bit indices OVP=0, UVLO=1, OTP=2, TMO=3;
  - the duty width constant DUTY_W=10.
- One sub-module, seq_fault_filter: parameterised threshold, compare direction and count; ports i_clk, reset_n, i_valid, i_code, o_trip, o_viol. Instantiated three times.

## Test plan
- Start from IDLE, i_ss_done after 500 cycles, i_comp_duty=950 → SOFT_START then REGULATE; o_ton=900 (DMAX clamp); o_comp_en=1.
- In REGULATE with o_ton=400, assert i_stop → o_sd_load single pulse with o_ton=400; SHUTDOWN; i_sd_done → IDLE, o_ton=0.
- In REGULATE, 3 samples with i_adc_vo=3600, then one good sample, then 4 bad samples → no trip until the 4th consecutive bad sample; FAULT next cycle; o_fault=4'b0001.
- i_adc_vin=1000 in IDLE with i_start=1 → stays IDLE; set vin=2000 and send 1 valid sample → SOFT_START.
- Hold i_ss_done=0 with SS_TIMEOUT=100 → FAULT after 100 cycles, o_fault=4'b1000. i_clear with i_start=1 is ignored; with i_start=0 → IDLE, o_fault=0.
- Pull reset_n low during SHUTDOWN → all outputs 0 asynchronously; state IDLE after release.
